// File: rtl/ray_pkg.sv
// Shared types for the ray dispatcher: ray payload, dispatcher FSM states and
// index-width helpers used to size round-robin and FIFO pointers.
package ray_pkg;

    localparam int RAY_POS_W          = 16;
    localparam int RAY_ADDR_W         = 32;
    localparam int DEFAULT_NUM_UNITS  = 4;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef struct packed {
        logic signed [2:0][RAY_POS_W-1:0] v;
        logic [RAY_ADDR_W-1:0]            address;
    } ray_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } dispatch_state_e;

    // Index width that never collapses to zero for single-entry configurations.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int UNIT_IDX_W = idx_width(DEFAULT_NUM_UNITS);
    localparam int FIFO_PTR_W = idx_width(DEFAULT_FIFO_DEPTH);

endpackage

// File: rtl/ray_fifo.sv
// Small synchronous FIFO for ray payloads with a registered occupancy count.
// DEPTH must be a power of two so the read/write pointers wrap naturally.
module ray_fifo
    import ray_pkg::*;
#(
    parameter type T     = ray_t,
    parameter int  DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    output T                           head,
    output logic                       full,
    output logic                       empty,
    output logic [idx_width(DEPTH):0]  count
);

    localparam int PTR_W = idx_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // A simultaneous push and pop leaves the count alone while both pointers move.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ray_dispatcher.sv
// Buffers generated rays and issues them round-robin to ready ray units.
// Define RAY_DISPATCH_STATS_EN to add per-unit grant and stall counters.
module ray_dispatcher
    import ray_pkg::*;
#(
    parameter int POSITION_WIDTH = RAY_POS_W,
    parameter int ADDRESS_WIDTH  = RAY_ADDR_W,
    parameter int NUM_UNITS      = DEFAULT_NUM_UNITS,
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH
) (
    input  logic                                              clock,
    input  logic                                              resetN,
    input  logic signed [2:0][POSITION_WIDTH-1:0]             rayV,
    input  logic [ADDRESS_WIDTH-1:0]                          rayAddress,
    input  logic                                              rayStart,
    output logic                                              rayReady,
    output logic                                              rayBusy,
    output logic [NUM_UNITS-1:0][2:0][POSITION_WIDTH-1:0]     unitV,
    output logic [NUM_UNITS-1:0][ADDRESS_WIDTH-1:0]           unitAddress,
    output logic [NUM_UNITS-1:0]                              unitStart,
    input  logic [NUM_UNITS-1:0]                              unitReady,
    input  logic [NUM_UNITS-1:0]                              unitBusy,
    output logic                                              idle
`ifdef RAY_DISPATCH_STATS_EN
    ,
    output logic [NUM_UNITS-1:0][31:0]                        unitIssued,
    output logic [31:0]                                       stallCycles
`endif
);

    localparam int UNIT_W = idx_width(NUM_UNITS);
    localparam int CNT_W  = idx_width(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [2:0][POSITION_WIDTH-1:0] v;
        logic [ADDRESS_WIDTH-1:0]       address;
    } entry_t;

    entry_t            push_data;
    entry_t            head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty_next;
    logic              accept_en;
    logic              push;
    logic              pop;

    logic [NUM_UNITS-1:0] eligible;
    logic [UNIT_W-1:0]    rr_ptr;
    logic [UNIT_W-1:0]    grant_idx;
    logic                 grant_valid;
    logic [UNIT_W:0]      cand;
    logic [UNIT_W-1:0]    cand_idx;

    dispatch_state_e state;
    dispatch_state_e state_next;

    assign push_data.v       = rayV;
    assign push_data.address = rayAddress;

    // accept_en keeps rayReady low until the first edge after reset is released.
    assign rayReady = accept_en && !fifo_full;
    assign push     = rayStart && rayReady;
    assign pop      = grant_valid;
    assign eligible = unitReady & ~unitStart;
    assign rayBusy  = !fifo_empty || (|unitStart) || (|unitBusy);
    assign idle     = (state == IDLE);

    assign fifo_empty_next = push ? 1'b0
                                  : (fifo_empty || (pop && fifo_count == CNT_W'(1)));

    ray_fifo #(
        .T     (entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .resetN    (resetN),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Round-robin search starting at rr_ptr and wrapping past the last unit.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            cand = {1'b0, rr_ptr} + (UNIT_W + 1)'(k);
            if (cand >= (UNIT_W + 1)'(NUM_UNITS)) begin
                cand = cand - (UNIT_W + 1)'(NUM_UNITS);
            end
            cand_idx = cand[UNIT_W-1:0];
            if (!grant_valid && !fifo_empty && eligible[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            accept_en   <= 1'b0;
            rr_ptr      <= '0;
            unitStart   <= '0;
            unitV       <= '0;
            unitAddress <= '0;
        end else begin
            accept_en <= 1'b1;
            unitStart <= '0;
            if (grant_valid) begin
                unitV[grant_idx]       <= head.v;
                unitAddress[grant_idx] <= head.address;
                unitStart[grant_idx]   <= 1'b1;
                rr_ptr <= (grant_idx == UNIT_W'(NUM_UNITS - 1)) ? '0
                                                                : grant_idx + UNIT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN waits for every issued ray to be picked up and finished before going idle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (push) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (fifo_empty_next) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (push) begin
                    state_next = ACTIVE;
                end else if (!(|unitStart) && !(|unitBusy) && fifo_empty) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef RAY_DISPATCH_STATS_EN
    logic stall;
    logic clear_stats;

    assign stall       = !fifo_empty && !grant_valid;
    assign clear_stats = (state == IDLE) && (state_next == ACTIVE);

    // Counters restart with each new frame and stick at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            unitIssued  <= '0;
            stallCycles <= '0;
        end else if (clear_stats) begin
            unitIssued  <= '0;
            stallCycles <= '0;
        end else begin
            if (stall && stallCycles != '1) begin
                stallCycles <= stallCycles + 32'd1;
            end
            if (grant_valid && unitIssued[grant_idx] != '1) begin
                unitIssued[grant_idx] <= unitIssued[grant_idx] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ray_dispatcher.sv
// Self-checking bench for ray_dispatcher: a queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_ray_dispatcher;

    localparam int PW = 16;
    localparam int AW = 32;
    localparam int NU = 4;
    localparam int FD = 4;

    logic                          clock = 1'b0;
    logic                          resetN = 1'b0;
    logic signed [2:0][PW-1:0]     rayV;
    logic [AW-1:0]                 rayAddress;
    logic                          rayStart;
    logic                          rayReady;
    logic                          rayBusy;
    logic [NU-1:0][2:0][PW-1:0]    unitV;
    logic [NU-1:0][AW-1:0]         unitAddress;
    logic [NU-1:0]                 unitStart;
    logic [NU-1:0]                 unitReady;
    logic [NU-1:0]                 unitBusy;
    logic                          idle;
`ifdef RAY_DISPATCH_STATS_EN
    logic [NU-1:0][31:0]           unitIssued;
    logic [31:0]                   stallCycles;
`endif

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clock = ~clock;

    ray_dispatcher #(
        .POSITION_WIDTH (PW),
        .ADDRESS_WIDTH  (AW),
        .NUM_UNITS      (NU),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clock       (clock),
        .resetN      (resetN),
        .rayV        (rayV),
        .rayAddress  (rayAddress),
        .rayStart    (rayStart),
        .rayReady    (rayReady),
        .rayBusy     (rayBusy),
        .unitV       (unitV),
        .unitAddress (unitAddress),
        .unitStart   (unitStart),
        .unitReady   (unitReady),
        .unitBusy    (unitBusy),
        .idle        (idle)
`ifdef RAY_DISPATCH_STATS_EN
        ,
        .unitIssued  (unitIssued),
        .stallCycles (stallCycles)
`endif
    );

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a ray queue, per-unit held outputs and a frame phase.
    typedef struct packed {
        logic [2:0][PW-1:0] v;
        logic [AW-1:0]      a;
    } ray_s;

    ray_s                       mq[$];
    logic [NU-1:0][2:0][PW-1:0] m_v;
    logic [NU-1:0][AW-1:0]      m_addr;
    logic [NU-1:0]              m_start;
    int                         m_rr;
    bit                         m_open;
    int                         m_phase;
    int                         m_issued[NU];
    int                         m_stall;

    function automatic void model_reset();
        mq.delete();
        m_v     = '0;
        m_addr  = '0;
        m_start = '0;
        m_rr    = 0;
        m_open  = 1'b0;
        m_phase = 0;
        m_stall = 0;
        for (int i = 0; i < NU; i++) m_issued[i] = 0;
    endfunction

    function automatic void model_step();
        bit   push_now;
        bit   was_empty;
        bit   any_start;
        int   g;
        ray_s r;
        push_now  = rayStart && m_open && (mq.size() < FD);
        was_empty = (mq.size() == 0);
        any_start = (m_start != '0);
        g = -1;
        if (!was_empty) begin
            for (int k = 0; k < NU; k++) begin
                int u;
                u = (m_rr + k) % NU;
                if (g < 0 && unitReady[u] && !m_start[u]) g = u;
            end
        end
        if (m_phase == 0 && push_now) begin
            m_stall = 0;
            for (int i = 0; i < NU; i++) m_issued[i] = 0;
        end else begin
            if (!was_empty && g < 0) m_stall++;
            if (g >= 0) m_issued[g]++;
        end
        m_start = '0;
        if (g >= 0) begin
            r = mq.pop_front();
            m_v[g]     = r.v;
            m_addr[g]  = r.a;
            m_start[g] = 1'b1;
            m_rr       = (g + 1) % NU;
        end
        if (push_now) begin
            r.v = rayV;
            r.a = rayAddress;
            mq.push_back(r);
        end
        case (m_phase)
            0: if (push_now) m_phase = 1;
            1: if (mq.size() == 0) m_phase = 2;
            default: begin
                if (push_now) m_phase = 1;
                else if (!any_start && unitBusy == '0 && was_empty) m_phase = 0;
            end
        endcase
        m_open = 1'b1;
    endfunction

    always @(posedge clock or negedge resetN) begin
        if (!resetN) model_reset();
        else model_step();
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check_output("rayReady", 256'(rayReady), 256'(m_open && mq.size() < FD));
            check_output("rayBusy", 256'(rayBusy),
                         256'(mq.size() > 0 || m_start != '0 || unitBusy != '0));
            check_output("unitStart", 256'(unitStart), 256'(m_start));
            check_output("unitV", 256'(unitV), 256'(m_v));
            check_output("unitAddress", 256'(unitAddress), 256'(m_addr));
            check_output("idle", 256'(idle), 256'(m_phase == 0));
`ifdef RAY_DISPATCH_STATS_EN
            check_output("stallCycles", 256'(stallCycles), 256'(m_stall));
            for (int i = 0; i < NU; i++)
                check_output("unitIssued", 256'(unitIssued[i]), 256'(m_issued[i]));
`endif
        end
    end

    int          grant_log[$];
    logic [31:0] grant_addr[$];

    always @(negedge clock) begin
        for (int i = 0; i < NU; i++) begin
            if (unitStart[i] === 1'b1) begin
                grant_log.push_back(i);
                grant_addr.push_back(unitAddress[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Drives one ray and holds it until accepted or the wait bound expires.
    task automatic apply_stimulus(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                  input logic [PW-1:0] z, input logic [AW-1:0] addr,
                                  input int max_wait, output bit ok);
        bit seen;
        rayV[0]    = x;
        rayV[1]    = y;
        rayV[2]    = z;
        rayAddress = addr;
        rayStart   = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < max_wait && !ok; c++) begin
            @(negedge clock);
            seen = rayReady;
            tick();
            ok = seen;
        end
        rayStart = 1'b0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 20 && idle !== 1'b1; c++) tick();
        check_output(name, 256'(idle), 256'(1));
    endtask

    initial begin
        bit ok;
        int accepted;
        int exp_units[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

        rayStart   = 1'b0;
        rayV       = '0;
        rayAddress = '0;
        unitReady  = '0;
        unitBusy   = '0;
        tick();
        cmp_en = 1'b1;

        check_output("reset_rayReady", 256'(rayReady), 256'(0));
        check_output("reset_idle", 256'(idle), 256'(1));
        check_output("reset_unitStart", 256'(unitStart), 256'(0));
        check_output("reset_rayBusy", 256'(rayBusy), 256'(0));
        check_output("reset_unitV", 256'(unitV), 256'(0));
        resetN = 1'b1;
        tick();
        check_output("ready_after_reset", 256'(rayReady), 256'(1));

        $display("[TB] single ray");
        unitReady = '1;
        apply_stimulus(16'd100, -16'sd200, 16'd300, 32'h1000, 4, ok);
        check_output("t1_accept", 256'(ok), 256'(1));
        check_output("t1_no_early_start", 256'(unitStart), 256'(0));
        tick();
        check_output("t1_unitStart", 256'(unitStart), 256'(4'b0001));
        check_output("t1_unitV0", 256'(unitV[0]), 256'(48'h012C_FF38_0064));
        check_output("t1_unitAddress0", 256'(unitAddress[0]), 256'(32'h1000));
        unitBusy = 4'b0001;
        tick();
        tick();
        check_output("t1_busy_not_idle", 256'(idle), 256'(0));
        check_output("t1_rayBusy", 256'(rayBusy), 256'(1));
        unitBusy = '0;
        wait_idle("t1_idle");

        $display("[TB] back-to-back rays");
        do_reset();
        grant_log.delete();
        grant_addr.delete();
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(16'(i), 16'(i + 1), 16'(i + 2), 32'h2000 + 32'(i), 4, ok);
            check_output("t2_accept", 256'(ok), 256'(1));
        end
        wait_idle("t2_idle");
        check_output("t2_grant_count", 256'(grant_log.size()), 256'(8));
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            check_output("t2_grant_unit", 256'(grant_log[i]), 256'(exp_units[i]));
            check_output("t2_grant_addr", 256'(grant_addr[i]), 256'(32'h2000 + 32'(i)));
        end

        $display("[TB] no ready units");
        unitReady = '0;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(16'd7, 16'd8, 16'd9, 32'h3000 + 32'(i), 1, ok);
            if (ok) accepted++;
        end
        check_output("t3_accepted", 256'(accepted), 256'(4));
        check_output("t3_rayReady_low", 256'(rayReady), 256'(0));
        check_output("t3_rayBusy", 256'(rayBusy), 256'(1));
        unitReady = 4'b0100;
        tick();
        unitReady = '0;
        check_output("t3_unitStart", 256'(unitStart), 256'(4'b0100));
        check_output("t3_unitAddress2", 256'(unitAddress[2]), 256'(32'h3000));

        $display("[TB] full with simultaneous pop");
        apply_stimulus(16'd1, 16'd2, 16'd3, 32'h3100, 2, ok);
        check_output("t4_fill", 256'(ok), 256'(1));
        rayV       = '0;
        rayAddress = 32'h3200;
        rayStart   = 1'b1;
        unitReady  = 4'b0010;
        @(negedge clock);
        check_output("t4_full_ready", 256'(rayReady), 256'(0));
        tick();
        unitReady = '0;
        check_output("t4_pop_unitStart", 256'(unitStart), 256'(4'b0010));
        check_output("t4_pop_addr", 256'(unitAddress[1]), 256'(32'h3001));
        check_output("t4_ready_after_pop", 256'(rayReady), 256'(1));
        tick();
        rayStart = 1'b0;
        check_output("t4_full_again", 256'(rayReady), 256'(0));

        $display("[TB] reset mid-frame");
        unitBusy  = 4'b0100;
        unitReady = 4'b1000;
        tick();
        unitReady = '0;
        check_output("t5_pop_addr", 256'(unitAddress[3]), 256'(32'h3002));
        resetN = 1'b0;
        #1;
        check_output("t5_rayReady", 256'(rayReady), 256'(0));
        check_output("t5_unitStart", 256'(unitStart), 256'(0));
        check_output("t5_unitV", 256'(unitV), 256'(0));
        check_output("t5_unitAddress", 256'(unitAddress), 256'(0));
        check_output("t5_idle", 256'(idle), 256'(1));
        unitBusy = '0;
        #1;
        check_output("t5_rayBusy", 256'(rayBusy), 256'(0));
        tick();
        resetN    = 1'b1;
        unitReady = '1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_output("t5_no_start", 256'(unitStart), 256'(0));
        end
        check_output("t5_idle_after", 256'(idle), 256'(1));

`ifdef RAY_DISPATCH_STATS_EN
        $display("[TB] statistics");
        do_reset();
        unitReady = '0;
        apply_stimulus(16'd5, 16'd5, 16'd5, 32'h6000, 2, ok);
        check_output("t6_accept", 256'(ok), 256'(1));
        tick();
        tick();
        unitReady = 4'b0001;
        tick();
        for (int i = 1; i < 5; i++) begin
            apply_stimulus(16'd5, 16'd5, 16'd5, 32'h6000 + 32'(i), 2, ok);
            check_output("t6_accept", 256'(ok), 256'(1));
            tick();
        end
        tick();
        check_output("t6_stallCycles", 256'(stallCycles), 256'(2));
        check_output("t6_unitIssued0", 256'(unitIssued[0]), 256'(5));
        check_output("t6_unitIssued_rest", 256'(unitIssued[NU-1:1]), 256'(0));
`endif

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
